// File: rtl/uart_rx_deframe_fifo_if.sv
// Bundle between the Rx SIPO, the deframer and its consumer. The slave side
// is the deframer: it takes frames in and presents buffered words out.
interface uart_rx_deframe_fifo_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int PARITY_MODE = 2,
   parameter int STOP_BITS   = 1,
   parameter int DEPTH       = 4
);
   localparam int FRAME_W = 1 + DATA_WIDTH + ((PARITY_MODE != 0) ? 1 : 0) + STOP_BITS;
   localparam int LVL_W   = $clog2(DEPTH + 1);

   logic                  recieved_flag;
   logic [FRAME_W-1:0]    data_parll;
   logic                  out_ready;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] raw_data;
   logic                  parity_error;
   logic                  framing_error;
   logic                  done_flag;
   logic                  overrun;
   logic [LVL_W-1:0]      fifo_level;

   modport master (
      output recieved_flag, data_parll, out_ready,
      input  out_valid, raw_data, parity_error, framing_error,
             done_flag, overrun, fifo_level
   );

   modport slave (
      input  recieved_flag, data_parll, out_ready,
      output out_valid, raw_data, parity_error, framing_error,
             done_flag, overrun, fifo_level
   );
endinterface

// File: rtl/uart_rx_deframe_fifo.sv
// UART receive deframer: strips start/parity/stop bits from a parallel frame,
// flags parity and framing errors, and queues {framing, parity, data} in a
// small FIFO read through a valid/ready handshake.
module uart_rx_deframe_fifo #(
   parameter int DATA_WIDTH  = 8,
   parameter int PARITY_MODE = 2,
   parameter int STOP_BITS   = 1,
   parameter int DEPTH       = 4
) (
   input logic clock,
   input logic reset_n,
   uart_rx_deframe_fifo_if.slave bus
);
   localparam int PAR_EN  = (PARITY_MODE != 0) ? 1 : 0;
   localparam int FRAME_W = 1 + DATA_WIDTH + PAR_EN + STOP_BITS;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LVL_W   = $clog2(DEPTH + 1);
   localparam int ENTRY_W = DATA_WIDTH + 2;
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

   logic                  flag_q;
   logic                  capture;
   logic                  push;
   logic                  pop;
   logic                  start_bit;
   logic                  par_bit;
   logic [DATA_WIDTH-1:0] data_w;
   logic [STOP_BITS-1:0]  stop_w;
   logic                  perr_w;
   logic                  ferr_w;
   logic [ENTRY_W-1:0]    mem [DEPTH];
   logic [ENTRY_W-1:0]    head;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [LVL_W-1:0]      level;
   logic                  done_q;
   logic                  overrun_q;

   // Field extraction. With parity disabled the bit above the data is a stop
   // bit; par_bit is then simply ignored.
   assign start_bit = bus.data_parll[0];
   assign data_w    = bus.data_parll[DATA_WIDTH:1];
   assign par_bit   = bus.data_parll[DATA_WIDTH+1];
   assign stop_w    = bus.data_parll[FRAME_W-1 -: STOP_BITS];

   // Parity and framing checks on the frame being captured.
   always_comb begin
      perr_w = 1'b0;
      case (PARITY_MODE)
         1:       perr_w = ~(^{data_w, par_bit});
         2:       perr_w = ^{data_w, par_bit};
         default: perr_w = 1'b0;
      endcase
      ferr_w = start_bit | ~(&stop_w);
   end

   // A frame is taken only on a low-to-high flag transition; a full FIFO
   // still accepts it if the head leaves in the same cycle.
   assign capture = bus.recieved_flag & ~flag_q;
   assign pop     = bus.out_valid & bus.out_ready;
   assign push    = capture & ((level < DEPTH_L) | pop);

   // Edge-detect register resets high so a flag already high at release is ignored.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) flag_q <= 1'b1;
      else          flag_q <= bus.recieved_flag;
   end

   // Storage array; contents are don't-care until covered by the level.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= {ferr_w, perr_w, data_w};
   end

   // Pointers, occupancy and the one-cycle event pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         done_q    <= push;
         overrun_q <= capture & ~push;
      end
   end

   // Head outputs are forced to zero while empty so stale storage never shows.
   assign head              = (level != '0) ? mem[rd_ptr] : '0;
   assign bus.out_valid     = (level != '0);
   assign bus.raw_data      = head[DATA_WIDTH-1:0];
   assign bus.parity_error  = head[DATA_WIDTH];
   assign bus.framing_error = head[DATA_WIDTH+1];
   assign bus.done_flag     = done_q;
   assign bus.overrun       = overrun_q;
   assign bus.fifo_level    = level;
endmodule

// File: tb/tb_uart_rx_deframe_fifo.sv
// Bench for uart_rx_deframe_fifo: a default-configuration instance and a
// 7-bit / odd-parity / 2-stop instance. Expected head words are queued as
// frames are sent; monitors pop and compare on each accepted handshake.
module tb_uart_rx_deframe_fifo;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   uart_rx_deframe_fifo_if #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(1), .DEPTH(4)) bus ();
   uart_rx_deframe_fifo #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(1), .DEPTH(4)) dut (
      .clock(clock), .reset_n(reset_n), .bus(bus));

   uart_rx_deframe_fifo_if #(.DATA_WIDTH(7), .PARITY_MODE(1), .STOP_BITS(2), .DEPTH(4)) bus2 ();
   uart_rx_deframe_fifo #(.DATA_WIDTH(7), .PARITY_MODE(1), .STOP_BITS(2), .DEPTH(4)) dut2 (
      .clock(clock), .reset_n(reset_n), .bus(bus2));

   int n_total = 0;
   int n_pass  = 0;
   logic [9:0] sb  [$];
   logic [8:0] sb2 [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Even-parity, one-stop frame for the default instance.
   function automatic logic [10:0] frm(input logic [7:0] d);
      return {1'b1, ^d, d, 1'b0};
   endfunction

   // Scoreboard monitor, default instance.
   always @(negedge clock) begin
      if (reset_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) chk("sb_unexpected_pop", {bus.framing_error, bus.parity_error, bus.raw_data}, 32'hFFFF);
         else chk("head_word", {bus.framing_error, bus.parity_error, bus.raw_data}, sb.pop_front());
      end
   end

   // Scoreboard monitor, 7-bit instance.
   always @(negedge clock) begin
      if (reset_n && bus2.out_valid && bus2.out_ready) begin
         if (sb2.size() == 0) chk("sb2_unexpected_pop", {bus2.framing_error, bus2.parity_error, bus2.raw_data}, 32'hFFFF);
         else chk("head_word2", {bus2.framing_error, bus2.parity_error, bus2.raw_data}, sb2.pop_front());
      end
   end

   task automatic send(input logic [10:0] f, input logic exp_push);
      bus.data_parll = f;
      bus.recieved_flag = 1'b1;
      tick();
      chk("done_flag", bus.done_flag, exp_push);
      chk("overrun", bus.overrun, !exp_push);
      bus.recieved_flag = 1'b0;
      tick();
   endtask

   task automatic drain();
      int i;
      bus.out_ready = 1'b1;
      for (i = 0; i < 20 && bus.out_valid; i++) tick();
      bus.out_ready = 1'b0;
      chk("drain_level", bus.fifo_level, 0);
      chk("drain_sb_empty", sb.size(), 0);
   endtask

   task automatic send2(input logic [10:0] f);
      bus2.data_parll = f;
      bus2.recieved_flag = 1'b1;
      tick();
      bus2.recieved_flag = 1'b0;
      tick();
   endtask

   initial begin
      int cnt;
      bus.recieved_flag = 1'b0;  bus.data_parll = '0;  bus.out_ready = 1'b0;
      bus2.recieved_flag = 1'b0; bus2.data_parll = '0; bus2.out_ready = 1'b0;
      #12;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_level", bus.fifo_level, 0);
      chk("rst_raw", bus.raw_data, 0);
      chk("rst_done", bus.done_flag, 0);
      reset_n = 1'b1;
      tick();

      // 1: clean frame
      sb.push_back({2'b00, 8'hA5});
      send(11'h54A, 1'b1);
      chk("t1_valid", bus.out_valid, 1);
      chk("t1_raw", bus.raw_data, 8'hA5);
      chk("t1_perr", bus.parity_error, 0);
      chk("t1_ferr", bus.framing_error, 0);
      chk("t1_level", bus.fifo_level, 1);
      bus.out_ready = 1'b1;
      tick();
      chk("t1_valid_after_pop", bus.out_valid, 0);
      bus.out_ready = 1'b0;

      // 2: error flags
      sb.push_back({2'b01, 8'hA5}); send(11'h74A, 1'b1);
      chk("t2_perr", bus.parity_error, 1);
      sb.push_back({2'b10, 8'hA5}); send(11'h14A, 1'b1);
      sb.push_back({2'b10, 8'hA5}); send(11'h54B, 1'b1);
      chk("t2_level", bus.fifo_level, 3);
      drain();

      // 3: held flag captures once
      sb.push_back({2'b00, 8'h3C});
      bus.data_parll = frm(8'h3C);
      bus.recieved_flag = 1'b1;
      cnt = 0;
      repeat (10) begin tick(); cnt += int'(bus.done_flag); end
      bus.recieved_flag = 1'b0;
      tick();
      chk("t3_done_count", cnt, 1);
      chk("t3_level", bus.fifo_level, 1);
      drain();

      // 4: full, overrun, pointer wrap
      for (int r = 0; r < 3; r++) begin
         for (int k = 1; k <= 5; k++) begin
            if (k <= 4) sb.push_back({2'b00, 8'(k)});
            send(frm(8'(k)), k <= 4);
         end
         chk("t4_level_full", bus.fifo_level, 4);
         drain();
      end

      // 5: full with simultaneous pop
      for (int k = 8'h11; k <= 8'h14; k++) begin
         sb.push_back({2'b00, 8'(k)});
         send(frm(8'(k)), 1'b1);
      end
      sb.push_back({2'b00, 8'h15});
      bus.data_parll = frm(8'h15);
      bus.recieved_flag = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("t5_done", bus.done_flag, 1);
      chk("t5_overrun", bus.overrun, 0);
      chk("t5_level", bus.fifo_level, 4);
      bus.recieved_flag = 1'b0;
      tick();
      drain();

      // 6: reset mid-stream, flag high at release
      for (int k = 8'h21; k <= 8'h23; k++) send(frm(8'(k)), 1'b1);
      chk("t6_level_pre", bus.fifo_level, 3);
      bus.data_parll = frm(8'h77);
      bus.recieved_flag = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("t6_valid", bus.out_valid, 0);
      chk("t6_level", bus.fifo_level, 0);
      chk("t6_raw", bus.raw_data, 0);
      chk("t6_errs", {bus.parity_error, bus.framing_error}, 0);
      chk("t6_pulses", {bus.done_flag, bus.overrun}, 0);
      tick(); tick();
      reset_n = 1'b1;
      cnt = 0;
      repeat (4) begin tick(); cnt += int'(bus.done_flag); end
      chk("t6_no_capture_done", cnt, 0);
      chk("t6_no_capture_level", bus.fifo_level, 0);
      bus.recieved_flag = 1'b0;
      tick();

      // 6b: 7 data bits, odd parity, two stop bits
      sb2.push_back({2'b00, 7'h55}); send2(11'b11_1_1010101_0);
      chk("t6b_done_level", bus2.fifo_level, 1);
      chk("t6b_errs", {bus2.framing_error, bus2.parity_error}, 0);
      sb2.push_back({2'b10, 7'h55}); send2(11'b01_1_1010101_0);
      sb2.push_back({2'b01, 7'h55}); send2(11'b11_0_1010101_0);
      chk("t6b_level", bus2.fifo_level, 3);
      bus2.out_ready = 1'b1;
      for (int i = 0; i < 20 && bus2.out_valid; i++) tick();
      bus2.out_ready = 1'b0;
      chk("t6b_drained", bus2.fifo_level, 0);
      chk("t6b_sb_empty", sb2.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
